// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the data_sync_hs CDC receiver.
// Contents: default parameter values, the event-detect function evt_f and the
// STABLE_ERR reset value.
package data_sync_pkg;

   localparam int unsigned DEF_NUM_STAGES  = 2;
   localparam int unsigned DEF_BUS_WIDTH   = 8;
   localparam int unsigned DEF_CNT_WIDTH   = 8;
   localparam bit          DEF_TOGGLE_MODE = 1'b1;

   localparam logic STABLE_ERR_RST = 1'b0;

   // Toggle protocol: any change of the synchronised enable is a word.
   // Level protocol: only a rising edge is a word.
   function automatic logic evt_f(input logic mode, input logic en_s, input logic en_d);
      return mode ? (en_s ^ en_d) : (en_s & ~en_d);
   endfunction

endpackage

// File: rtl/data_sync_hs_if.sv
// Handshake bundle between the source-domain word and the destination-domain
// receiver.
//   UNSYNC_BUS   : source word, held stable between enable events
//   BUS_ENABLE   : source word-valid indication (toggle or level)
//   SYNC_BUS     : captured word
//   ENABLE_PULSE : one-cycle strobe, SYNC_BUS updated
//   WORD_CNT     : captured-word count
//   STABLE_ERR   : sticky data-instability flag
// master = source/consumer side, slave = receiver.
interface data_sync_hs_if #(
   parameter int unsigned BUS_WIDTH = data_sync_pkg::DEF_BUS_WIDTH,
   parameter int unsigned CNT_WIDTH = data_sync_pkg::DEF_CNT_WIDTH
);
   logic [BUS_WIDTH-1:0] UNSYNC_BUS;
   logic                 BUS_ENABLE;
   logic [BUS_WIDTH-1:0] SYNC_BUS;
   logic                 ENABLE_PULSE;
   logic [CNT_WIDTH-1:0] WORD_CNT;
   logic                 STABLE_ERR;

   modport master (
      output UNSYNC_BUS, BUS_ENABLE,
      input  SYNC_BUS, ENABLE_PULSE, WORD_CNT, STABLE_ERR
   );

   modport slave (
      input  UNSYNC_BUS, BUS_ENABLE,
      output SYNC_BUS, ENABLE_PULSE, WORD_CNT, STABLE_ERR
   );
endinterface

// File: rtl/sync_ff_chain.sv
// Single-bit flop-chain synchroniser.
//   CLK      : destination clock
//   RST      : asynchronous active-low reset, clears every stage
//   async_in : source-domain bit
//   sync_out : last stage of the chain
module sync_ff_chain #(
   parameter int unsigned NUM_STAGES = data_sync_pkg::DEF_NUM_STAGES
) (
   input  logic CLK,
   input  logic RST,
   input  logic async_in,
   output logic sync_out
);
   logic [NUM_STAGES-1:0] sync_q;
   logic [NUM_STAGES-1:0] sync_d;

   // Shift toward the MSB; stage 0 is the only flop seeing the async input.
   always_comb begin
      sync_d = {sync_q[NUM_STAGES-2:0], async_in};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) sync_q <= '0;
      else      sync_q <= sync_d;
   end

   assign sync_out = sync_q[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_hs.sv
// Multi-bit CDC receiver (destination CLK domain). Only BUS_ENABLE is
// synchronised; the word is captured on the synchronised enable event.
//   CLK : destination clock
//   RST : asynchronous active-low reset
//   bus : data_sync_hs_if.slave (UNSYNC_BUS/BUS_ENABLE in;
//         SYNC_BUS/ENABLE_PULSE/WORD_CNT/STABLE_ERR out, all registered)
// Optional build macro DATA_SYNC_STABLE_CHECK_EN adds the post-capture
// stability checker; otherwise STABLE_ERR is tied low.
module data_sync_hs import data_sync_pkg::*; #(
   parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
   parameter int unsigned BUS_WIDTH   = DEF_BUS_WIDTH,
   parameter bit          TOGGLE_MODE = DEF_TOGGLE_MODE,
   parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic           CLK,
   input  logic           RST,
   data_sync_hs_if.slave  bus
);
   logic                 en_s;
   logic                 evt;
   logic                 en_d_q,         en_d_d;
   logic [BUS_WIDTH-1:0] sync_bus_q,     sync_bus_d;
   logic                 enable_pulse_q, enable_pulse_d;
   logic [CNT_WIDTH-1:0] word_cnt_q,     word_cnt_d;

   sync_ff_chain #(.NUM_STAGES(NUM_STAGES)) u_en_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (bus.BUS_ENABLE),
      .sync_out (en_s)
   );

   // Edge detect, capture and count.
   always_comb begin
      en_d_d         = en_s;
      evt            = evt_f(TOGGLE_MODE, en_s, en_d_q);
      sync_bus_d     = sync_bus_q;
      enable_pulse_d = evt;
      word_cnt_d     = word_cnt_q;
      if (evt) begin
         sync_bus_d = bus.UNSYNC_BUS;
         word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_d_q         <= 1'b0;
         sync_bus_q     <= '0;
         enable_pulse_q <= 1'b0;
         word_cnt_q     <= '0;
      end else begin
         en_d_q         <= en_d_d;
         sync_bus_q     <= sync_bus_d;
         enable_pulse_q <= enable_pulse_d;
         word_cnt_q     <= word_cnt_d;
      end
   end

   assign bus.SYNC_BUS     = sync_bus_q;
   assign bus.ENABLE_PULSE = enable_pulse_q;
   assign bus.WORD_CNT     = word_cnt_q;

`ifdef DATA_SYNC_STABLE_CHECK_EN
   logic stable_err_q, stable_err_d;

   // In the cycle after a capture the source word must still match the
   // captured one, and no new capture may land in that cycle.
   always_comb begin
      stable_err_d = stable_err_q;
      if (enable_pulse_q && ((bus.UNSYNC_BUS != sync_bus_q) || evt)) begin
         stable_err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) stable_err_q <= STABLE_ERR_RST;
      else      stable_err_q <= stable_err_d;
   end

   assign bus.STABLE_ERR = stable_err_q;
`else
   assign bus.STABLE_ERR = STABLE_ERR_RST;
`endif

endmodule

// File: tb/tb_data_sync_hs.sv
module tb_data_sync_hs;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

`ifdef DATA_SYNC_STABLE_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   data_sync_hs_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if_a ();
   data_sync_hs_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if_b ();
   data_sync_hs_if #(.BUS_WIDTH(8), .CNT_WIDTH(4)) if_c ();

   data_sync_hs #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(1'b1), .CNT_WIDTH(8)) u_tog (
      .CLK (CLK), .RST (RST), .bus (if_a)
   );
   data_sync_hs #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(1'b0), .CNT_WIDTH(8)) u_lvl (
      .CLK (CLK), .RST (RST), .bus (if_b)
   );
   data_sync_hs #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(1'b1), .CNT_WIDTH(4)) u_c4 (
      .CLK (CLK), .RST (RST), .bus (if_c)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int p;

      // 1. reset with random inputs
      if_a.UNSYNC_BUS = 8'($urandom); if_a.BUS_ENABLE = 1'($urandom);
      if_b.UNSYNC_BUS = 8'($urandom); if_b.BUS_ENABLE = 1'($urandom);
      if_c.UNSYNC_BUS = 8'($urandom); if_c.BUS_ENABLE = 1'($urandom);
      repeat (3) tick();
      chk("rst_sync_bus", 32'(if_a.SYNC_BUS), 32'h0);
      chk("rst_pulse",    32'(if_a.ENABLE_PULSE), 32'h0);
      chk("rst_cnt",      32'(if_a.WORD_CNT), 32'h0);
      chk("rst_err",      32'(if_a.STABLE_ERR), 32'h0);
      chk("rst_lvl_sync", 32'(if_b.SYNC_BUS), 32'h0);
      chk("rst_c4_cnt",   32'(if_c.WORD_CNT), 32'h0);
      if_a.BUS_ENABLE = 1'b0; if_b.BUS_ENABLE = 1'b0; if_c.BUS_ENABLE = 1'b0;
      if_a.UNSYNC_BUS = 8'h00; if_b.UNSYNC_BUS = 8'h00; if_c.UNSYNC_BUS = 8'h00;
      RST = 1'b1;
      p = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         p += int'(if_a.ENABLE_PULSE) + int'(if_b.ENABLE_PULSE) + int'(if_c.ENABLE_PULSE);
      end
      chk("idle_no_pulse", 32'(p), 32'd0);

      // 2. toggle mode, two words
      if_a.UNSYNC_BUS = 8'hA5; if_a.BUS_ENABLE = 1'b1;
      tick(); tick();
      chk("t2_not_early", 32'(if_a.ENABLE_PULSE), 32'h0);
      tick();
      chk("t2_pulse1",    32'(if_a.ENABLE_PULSE), 32'h1);
      chk("t2_data1",     32'(if_a.SYNC_BUS), 32'hA5);
      chk("t2_cnt1",      32'(if_a.WORD_CNT), 32'd1);
      tick();
      chk("t2_pulse1_end", 32'(if_a.ENABLE_PULSE), 32'h0);
      chk("t2_hold1",      32'(if_a.SYNC_BUS), 32'hA5);
      repeat (4) tick();
      if_a.UNSYNC_BUS = 8'h3C; if_a.BUS_ENABLE = 1'b0;
      repeat (3) tick();
      chk("t2_pulse2", 32'(if_a.ENABLE_PULSE), 32'h1);
      chk("t2_data2",  32'(if_a.SYNC_BUS), 32'h3C);
      chk("t2_cnt2",   32'(if_a.WORD_CNT), 32'd2);
      tick();
      chk("t2_pulse2_end", 32'(if_a.ENABLE_PULSE), 32'h0);
      repeat (4) tick();
      chk("t2_no_err", 32'(if_a.STABLE_ERR), 32'h0);

      // 3. level mode: rising edge only
      if_b.UNSYNC_BUS = 8'h5A; if_b.BUS_ENABLE = 1'b1;
      p = 0;
      for (int i = 0; i < 6; i++) begin tick(); p += int'(if_b.ENABLE_PULSE); end
      chk("t3_rise_pulses", 32'(p), 32'd1);
      chk("t3_data",        32'(if_b.SYNC_BUS), 32'h5A);
      if_b.BUS_ENABLE = 1'b0;
      p = 0;
      for (int i = 0; i < 8; i++) begin tick(); p += int'(if_b.ENABLE_PULSE); end
      chk("t3_fall_pulses", 32'(p), 32'd0);
      chk("t3_cnt",         32'(if_b.WORD_CNT), 32'd1);
      chk("t3_no_err",      32'(if_b.STABLE_ERR), 32'h0);

      // 4. 4-bit counter wrap over 17 words
      p = 0;
      for (int i = 0; i < 17; i++) begin
         if_c.BUS_ENABLE = ~if_c.BUS_ENABLE;
         if_c.UNSYNC_BUS = 8'(i + 1);
         for (int k = 0; k < 6; k++) begin tick(); p += int'(if_c.ENABLE_PULSE); end
         chk("t4_cnt_step", 32'(if_c.WORD_CNT), 32'((i + 1) % 16));
      end
      chk("t4_pulses",   32'(p), 32'd17);
      chk("t4_cnt_end",  32'(if_c.WORD_CNT), 32'd1);
      chk("t4_data_end", 32'(if_c.SYNC_BUS), 32'd17);
      chk("t4_no_err",   32'(if_c.STABLE_ERR), 32'h0);

      // 5. reset one cycle after a toggle discards it
      if_a.UNSYNC_BUS = 8'h77; if_a.BUS_ENABLE = 1'b1;
      tick();
      RST = 1'b0;
      if_a.BUS_ENABLE = 1'b0;
      #1;
      chk("t5_async_cnt",  32'(if_a.WORD_CNT), 32'd0);
      chk("t5_async_data", 32'(if_a.SYNC_BUS), 32'h0);
      tick();
      RST = 1'b1;
      p = 0;
      for (int i = 0; i < 8; i++) begin tick(); p += int'(if_a.ENABLE_PULSE); end
      chk("t5_no_pulse", 32'(p), 32'd0);
      chk("t5_cnt",      32'(if_a.WORD_CNT), 32'd0);

      // 6. source word changes in the capture cycle
      if_a.UNSYNC_BUS = 8'h11; if_a.BUS_ENABLE = 1'b1;
      repeat (3) tick();
      chk("t6_pulse", 32'(if_a.ENABLE_PULSE), 32'h1);
      chk("t6_data",  32'(if_a.SYNC_BUS), 32'h11);
      chk("t6_err_before", 32'(if_a.STABLE_ERR), 32'h0);
      if_a.UNSYNC_BUS = 8'h22;
      tick();
      chk("t6_err_set", 32'(if_a.STABLE_ERR), 32'(EXP_ERR));
      if_a.UNSYNC_BUS = 8'h11;
      repeat (5) tick();
      chk("t6_err_sticky", 32'(if_a.STABLE_ERR), 32'(EXP_ERR));
      RST = 1'b0;
      #1;
      chk("t6_err_cleared", 32'(if_a.STABLE_ERR), 32'h0);
      tick();
      RST = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
